ttt_game_controller: RTL
========================

Name: ttt_game_controller

Overview:
- Turn-sequencing FSM for the XO game: owns the 9-cell board register and alternates moves between the human player (X) and the computer move source (O).
- Gates each move request (legal, empty cell, correct turn), writes the cell, then evaluates win / board-full one cycle later.
- Drives pos1..pos9 to the display and the existing nospace_detector.
- Reports the game result and requests computer moves.

Parameters:
- TIMEOUT_CYCLES, 1000, player move timeout in clock cycles (used only with MOVE_TIMEOUT_EN).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: begin a new game from IDLE or DONE.
- play  in  1  one-cycle pulse: player move request.
- move_pos  in  4  player cell index, 1..9.
- pc  in  1  one-cycle pulse: computer move request.
- pc_pos  in  4  computer cell index, 1..9.
- pos1..pos9  out  2 each  board cells: 00 empty, 01 X/player, 10 O/computer; 11 never driven.
- who  out  2  result: 00 none, 01 player win, 10 computer win, 11 draw.
- player_turn  out  1  high in PLAYER state.
- pc_req  out  1  high in COMPUTER state.
- illegal_move  out  1  one-cycle pulse on a rejected request.
- move_count  out  4  accepted moves this game, 0..9.
- timeout  out  1  one-cycle pulse on player timeout.

Behaviour:
- Reset (asynchronous assert, synchronous release): state IDLE, all pos = 00, who = 00, move_count = 0, all pulse and status outputs 0.
- States: IDLE, PLAYER, COMPUTER, CHECK, DONE. A registered last_mover bit records who moved last.
- IDLE: on start, go to PLAYER. Player always opens.
- PLAYER:
  - play with move_pos in 1..9 and the addressed cell = 00: write 01, move_count +1, last_mover = player, go to CHECK.
  - play with move_pos 0 or 10..15, or with an occupied cell: illegal_move = 1 for one cycle, board unchanged, stay in PLAYER.
- COMPUTER: same rules using pc / pc_pos; writes 10.
- Requests in the wrong state (play outside PLAYER, pc outside COMPUTER) are ignored silently; illegal_move stays 0.
- If play and pc arrive in the same cycle, only the request owned by the current state is considered.
- CHECK (exactly one cycle) evaluates the registered board:
  - Any of the 8 lines (3 rows, 3 columns, 2 diagonals) all 01: who = 01, go to DONE.
  - Any line all 10: who = 10, go to DONE.
  - Otherwise, if no_space is set: who = 11, go to DONE.
  - Otherwise: go to the opposite of last_mover.
  - A win on the ninth move reports the win, never a draw.
- Latency: a move accepted at edge N appears on pos at N; who and the next turn are valid after edge N+1.
- DONE: board and who held; play and pc ignored. On start: clear all cells to 00, who = 00, move_count = 0, go to PLAYER, all in one edge.
- start in PLAYER, COMPUTER or CHECK is ignored. The only way to abort a game is reset.
- Reset asserted mid-game clears everything asynchronously, including during CHECK.
- move_count saturates at 9; by construction it never exceeds 9.

Optional Feature:
- Macro: MOVE_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES) clears on entry to PLAYER.
  - It increments each PLAYER cycle that has no legal play.
  - When it reaches TIMEOUT_CYCLES-1 with no legal play that cycle: timeout = 1 for one cycle, turn forfeited, go to COMPUTER with the board unchanged.
  - A legal play on the terminal cycle wins over the timeout.
  - Illegal requests do not clear the counter.
- Undefined: no counter is instantiated, timeout is tied to 0, and PLAYER waits indefinitely.

Decomposition:
- Package ttt_pkg:
  - Cell encodings EMPTY = 2'b00, CELL_X = 2'b01, CELL_O = 2'b10.
  - Result codes RES_NONE, RES_PLAYER, RES_PC, RES_DRAW.
  - FSM state encoding.
  - Constant NUM_CELLS = 9.
- Sub-module ttt_win_detector: combinational. Inputs pos1..pos9; outputs x_win and o_win from the 8-line checks.
- Board-full is computed by instantiating the existing nospace_detector.

Test Plan:
1. Reset, then start; player plays 1, 2, 3 while the computer plays 4, 5 → after the 3rd player move plus 1 cycle: who = 01, state DONE, move_count = 5, pos1..3 = 01.
2. Player plays cell 5, then plays 5 again on the next turn attempt (computer then also targets 5) → illegal_move pulses once per attempt, pos5 stays 01, turn is not advanced.
3. Full-board sequence with no line (X: 1,3,4,8,9; O: 2,5,6,7) → who = 11 one cycle after the 9th move, move_count = 9.
4. Ninth move completes an X line (X: 1,2,4,6,7 with X1-X4-X7; O: 3,5,8,9) → who = 01, not 11.
5. play and pc pulsed together in PLAYER with move_pos = 2 and pc_pos = 3 → only pos2 = 01, pos3 stays 00; move_pos = 0 → illegal_move = 1.
6. MOVE_TIMEOUT_EN defined with TIMEOUT_CYCLES = 8, no play → timeout pulses on the 8th PLAYER cycle, pc_req = 1 the next cycle, board unchanged. Reset asserted mid-game → all pos = 00, who = 00 immediately.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared encodings for the XO game controller: cell values, result codes,
// FSM states and small board helpers.
package ttt_pkg;

  localparam int unsigned NUM_CELLS = 9;

  localparam logic [1:0] EMPTY  = 2'b00;
  localparam logic [1:0] CELL_X = 2'b01;
  localparam logic [1:0] CELL_O = 2'b10;

  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_PLAYER = 2'b01;
  localparam logic [1:0] RES_PC     = 2'b10;
  localparam logic [1:0] RES_DRAW   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAYER,
    ST_COMPUTER,
    ST_CHECK,
    ST_DONE
  } state_t;

  function automatic logic pos_valid(input logic [3:0] p);
    return (p >= 4'd1) && (p <= 4'd9);
  endfunction

  function automatic logic line3(input logic [1:0] a, input logic [1:0] b,
                                 input logic [1:0] c, input logic [1:0] v);
    return (a == v) && (b == v) && (c == v);
  endfunction

endpackage

// File: rtl/nospace_detector.sv
// Board-full detector: asserts no_space when none of the nine cells is empty.
module nospace_detector (
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  input  logic [1:0] pos9,
  output logic       no_space
);

  assign no_space = (pos1 != 2'b00) && (pos2 != 2'b00) && (pos3 != 2'b00) &&
                    (pos4 != 2'b00) && (pos5 != 2'b00) && (pos6 != 2'b00) &&
                    (pos7 != 2'b00) && (pos8 != 2'b00) && (pos9 != 2'b00);

endmodule

// File: rtl/ttt_win_detector.sv
// Combinational three-in-a-row check over the 3 rows, 3 columns and 2 diagonals.
module ttt_win_detector
  import ttt_pkg::*;
(
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  input  logic [1:0] pos9,
  output logic       x_win,
  output logic       o_win
);

  function automatic logic has_line(input logic [1:0] v);
    return line3(pos1, pos2, pos3, v) || line3(pos4, pos5, pos6, v) ||
           line3(pos7, pos8, pos9, v) || line3(pos1, pos4, pos7, v) ||
           line3(pos2, pos5, pos8, v) || line3(pos3, pos6, pos9, v) ||
           line3(pos1, pos5, pos9, v) || line3(pos3, pos5, pos7, v);
  endfunction

  assign x_win = has_line(CELL_X);
  assign o_win = has_line(CELL_O);

endmodule

// File: rtl/ttt_game_controller.sv
// XO turn sequencer: owns the board, gates player/computer moves, judges results.
// Define MOVE_TIMEOUT_EN to forfeit the player's turn after TIMEOUT_CYCLES idle cycles.
module ttt_game_controller
  import ttt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       play,
  input  logic [3:0] move_pos,
  input  logic       pc,
  input  logic [3:0] pc_pos,
  output logic [1:0] pos1,
  output logic [1:0] pos2,
  output logic [1:0] pos3,
  output logic [1:0] pos4,
  output logic [1:0] pos5,
  output logic [1:0] pos6,
  output logic [1:0] pos7,
  output logic [1:0] pos8,
  output logic [1:0] pos9,
  output logic [1:0] who,
  output logic       player_turn,
  output logic       pc_req,
  output logic       illegal_move,
  output logic [3:0] move_count,
  output logic       timeout
);

  state_t     state, state_d;
  logic [1:0] board [NUM_CELLS];
  logic [1:0] who_d;
  logic       last_mover;   // 1: computer moved last
  logic       wr_en, new_game;
  logic [3:0] wr_idx;
  logic [1:0] wr_val;
  logic [3:0] play_idx, pc_idx;
  logic       play_legal, pc_legal;
  logic       x_win, o_win, no_space;
  logic       tmo_hit;

  assign play_idx   = pos_valid(move_pos) ? move_pos - 4'd1 : 4'd0;
  assign pc_idx     = pos_valid(pc_pos)   ? pc_pos   - 4'd1 : 4'd0;
  assign play_legal = pos_valid(move_pos) && (board[play_idx] == EMPTY);
  assign pc_legal   = pos_valid(pc_pos)   && (board[pc_idx]   == EMPTY);

  assign {pos1, pos2, pos3} = {board[0], board[1], board[2]};
  assign {pos4, pos5, pos6} = {board[3], board[4], board[5]};
  assign {pos7, pos8, pos9} = {board[6], board[7], board[8]};

  assign player_turn = (state == ST_PLAYER);
  assign pc_req      = (state == ST_COMPUTER);

  ttt_win_detector u_win (
    .pos1(pos1), .pos2(pos2), .pos3(pos3),
    .pos4(pos4), .pos5(pos5), .pos6(pos6),
    .pos7(pos7), .pos8(pos8), .pos9(pos9),
    .x_win(x_win), .o_win(o_win)
  );

  nospace_detector u_nospace (
    .pos1(pos1), .pos2(pos2), .pos3(pos3),
    .pos4(pos4), .pos5(pos5), .pos6(pos6),
    .pos7(pos7), .pos8(pos8), .pos9(pos9),
    .no_space(no_space)
  );

`ifdef MOVE_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_cnt;

  // Staying in PLAYER implies no legal play; any exit clears for the next entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if ((state != ST_PLAYER) || (state_d != ST_PLAYER)) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  assign tmo_hit = (state == ST_PLAYER) && (tmo_cnt == CNT_LAST);
`else
  // Parameter kept on the interface; without the timeout build it has no effect.
  assign tmo_hit = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d      = state;
    who_d        = who;
    wr_en        = 1'b0;
    wr_idx       = play_idx;
    wr_val       = CELL_X;
    new_game     = 1'b0;
    illegal_move = 1'b0;
    timeout      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          new_game = 1'b1;
          state_d  = ST_PLAYER;
        end
      end
      ST_PLAYER: begin
        if (play && play_legal) begin
          wr_en   = 1'b1;
          state_d = ST_CHECK;
        end else begin
          illegal_move = play;
          if (tmo_hit) begin
            timeout = 1'b1;
            state_d = ST_COMPUTER;
          end
        end
      end
      ST_COMPUTER: begin
        if (pc && pc_legal) begin
          wr_en   = 1'b1;
          wr_idx  = pc_idx;
          wr_val  = CELL_O;
          state_d = ST_CHECK;
        end else begin
          illegal_move = pc;
        end
      end
      ST_CHECK: begin
        if (x_win) begin
          who_d   = RES_PLAYER;
          state_d = ST_DONE;
        end else if (o_win) begin
          who_d   = RES_PC;
          state_d = ST_DONE;
        end else if (no_space) begin
          who_d   = RES_DRAW;
          state_d = ST_DONE;
        end else begin
          state_d = last_mover ? ST_PLAYER : ST_COMPUTER;
        end
      end
      ST_DONE: begin
        if (start) begin
          new_game = 1'b1;
          who_d    = RES_NONE;
          state_d  = ST_PLAYER;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      who        <= RES_NONE;
      move_count <= '0;
      last_mover <= 1'b0;
      for (int unsigned i = 0; i < NUM_CELLS; i++) board[i] <= EMPTY;
    end else begin
      state <= state_d;
      who   <= who_d;
      if (new_game) begin
        move_count <= '0;
        last_mover <= 1'b0;
        for (int unsigned i = 0; i < NUM_CELLS; i++) board[i] <= EMPTY;
      end else if (wr_en) begin
        board[wr_idx] <= wr_val;
        last_mover    <= (wr_val == CELL_O);
        if (move_count != 4'd9) move_count <= move_count + 4'd1;
      end
    end
  end

endmodule
